// File: rtl/ldl_crc32_pkg.sv
// Shared constants, state type and byte-step helper for the Ethernet FCS checker.
// Register form is non-reflected; each byte enters LSB first, as on the wire.
package ldl_crc32_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  typedef enum logic {
    IDLE,
    FRAME
  } crc_chk_state_t;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ b[i]) ? CRC32_POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/LDL_crc32_dn.sv
// Combinational multi-byte CRC32 step; lane NUM-1 goes first.
// bnum limits the bytes consumed from lane NUM-1 downward; 0 means all lanes.
module LDL_crc32_dn
  import ldl_crc32_pkg::*;
#(
  parameter int NUM = 4
) (
  input  logic [NUM-1:0][7:0]     data,
  input  logic [$clog2(NUM)-1:0]  bnum,
  input  logic [31:0]             crc_in,
  output logic [31:0]             crc_out
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_in;
    for (int l = NUM - 1; l >= 0; l--) begin
      if (bnum == '0 || (NUM - 1 - l) < int'(bnum)) begin
        acc = crc32_byte(acc, data[l]);
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/ldl_crc32_stream_chk.sv
// Streaming Ethernet FCS checker: 1-cycle pass-through with FCS status on eop.
// Define LDL_CRC32_CHK_STAT_EN to add saturating good/bad frame counters.
module ldl_crc32_stream_chk
  import ldl_crc32_pkg::*;
#(
  parameter int          NUM     = 4,
  parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [NUM-1:0][7:0]     in_data,
  input  logic [$clog2(NUM)-1:0]  in_bnum,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [NUM-1:0][7:0]     out_data,
  output logic [$clog2(NUM)-1:0]  out_bnum,
  output logic                    out_fcs_ok,
  output logic                    out_abort,
`ifdef LDL_CRC32_CHK_STAT_EN
  input  logic                    stat_clr,
  output logic [31:0]             stat_good_cnt,
  output logic [31:0]             stat_bad_cnt,
`endif
  output logic                    out_err
);

  localparam int BW = $clog2(NUM);

  crc_chk_state_t state;
  logic [31:0]    crc_q;
  logic [31:0]    crc_in;
  logic [31:0]    crc_next;
  logic [BW-1:0]  bnum_eff;
  logic           act;
  logic           fin;
  logic           ok_d;
  logic           abort_d;
  logic           err_d;

  // A beat belongs to a frame if it opens one or one is already open.
  always_comb begin
    act      = in_valid & (in_sop | (state == FRAME));
    fin      = act & in_eop;
    crc_in   = in_sop ? CRC32_INIT : crc_q;
    bnum_eff = in_eop ? in_bnum : '0;
    ok_d     = fin & (crc_next == RESIDUE);
    abort_d  = in_valid & in_sop & (state == FRAME);
    err_d    = in_valid & in_eop & ~in_sop & (state == IDLE);
  end

  LDL_crc32_dn #(
    .NUM(NUM)
  ) u_dn (
    .data   (in_data),
    .bnum   (bnum_eff),
    .crc_in (crc_in),
    .crc_out(crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc_q      <= CRC32_INIT;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      out_bnum   <= '0;
      out_fcs_ok <= 1'b0;
      out_abort  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      out_valid  <= in_valid;
      out_sop    <= in_sop;
      out_eop    <= in_eop;
      out_data   <= in_data;
      out_bnum   <= in_bnum;
      out_fcs_ok <= ok_d;
      out_abort  <= abort_d;
      out_err    <= err_d;
      if (act) begin
        crc_q <= fin ? CRC32_INIT : crc_next;
      end
      if (in_valid) begin
        if (in_sop && !in_eop) begin
          state <= FRAME;
        end else if (in_eop) begin
          state <= IDLE;
        end
      end
    end
  end

`ifdef LDL_CRC32_CHK_STAT_EN
  logic [1:0]  bad_inc;
  logic [32:0] bad_sum;

  always_comb begin
    bad_inc = {1'b0, fin & ~ok_d} + {1'b0, abort_d};
    bad_sum = {1'b0, stat_bad_cnt} + {31'b0, bad_inc};
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_good_cnt <= '0;
      stat_bad_cnt  <= '0;
    end else begin
      if (ok_d && stat_good_cnt != 32'hFFFF_FFFF) begin
        stat_good_cnt <= stat_good_cnt + 32'd1;
      end
      stat_bad_cnt <= bad_sum[32] ? 32'hFFFF_FFFF : bad_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ldl_crc32_stream_chk.sv
// Randomized bench for ldl_crc32_stream_chk against a byte-queue frame model.
// Model uses the reflected (zlib-style) CRC32 and its 0xDEBB20E3 residue.
module tb_ldl_crc32_stream_chk;
  localparam int NUM = 4;
  localparam logic [31:0] GOOD = 32'hDEBB_20E3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sop, in_eop;
  logic [31:0] in_data;
  logic [1:0]  in_bnum;
  logic        out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic [1:0]  out_bnum;
  logic        out_fcs_ok, out_abort, out_err;
`ifdef LDL_CRC32_CHK_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_good_cnt, stat_bad_cnt;
  logic [31:0] m_good, m_bad;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic       open;
  logic [7:0] mbytes[$];
  logic [7:0] frm[$];
  logic [7:0] junk;
  logic       last_ok, last_abort, last_err;

  always #5 clk = ~clk;

  ldl_crc32_stream_chk #(.NUM(NUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_bnum   (in_bnum),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_data  (out_data),
    .out_bnum  (out_bnum),
    .out_fcs_ok(out_fcs_ok),
    .out_abort (out_abort),
`ifdef LDL_CRC32_CHK_STAT_EN
    .stat_clr     (stat_clr),
    .stat_good_cnt(stat_good_cnt),
    .stat_bad_cnt (stat_bad_cnt),
`endif
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_refl(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c;
  endfunction

  task automatic beat(input logic v, input logic s, input logic e,
                      input logic [31:0] d, input logic [1:0] b);
    logic ab, er, ok, fr;
    ab = 1'b0; er = 1'b0; ok = 1'b0; fr = 1'b0;
    in_valid = v; in_sop = s; in_eop = e; in_data = d; in_bnum = b;
    if (v) begin
      if (s) begin
        ab = open;
        mbytes.delete();
      end
      if (e && !s && !open) er = 1'b1;
      if (s || open) begin
        for (int l = NUM - 1; l >= 0; l--) begin
          if (!e || b == 0 || (NUM - 1 - l) < int'(b))
            mbytes.push_back(d[l*8+:8]);
        end
        if (e) begin
          ok = (crc_refl(mbytes) == GOOD);
          fr = 1'b1;
          open = 1'b0;
        end else begin
          open = 1'b1;
        end
      end
    end
`ifdef LDL_CRC32_CHK_STAT_EN
    if (stat_clr) begin
      m_good = 0; m_bad = 0;
    end else begin
      m_good += {31'b0, ok};
      m_bad  += {31'b0, fr & ~ok} + {31'b0, ab};
    end
`endif
    @(posedge clk);
    #1;
    check("status",
          {out_valid, out_sop, out_eop, out_bnum, out_fcs_ok, out_abort, out_err},
          {v, s, e, b, ok, ab, er});
    check("data", out_data, d);
`ifdef LDL_CRC32_CHK_STAT_EN
    check("good_cnt", stat_good_cnt, m_good);
    check("bad_cnt", stat_bad_cnt, m_bad);
`endif
    last_ok = out_fcs_ok; last_abort = out_abort; last_err = out_err;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_bnum = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      @(posedge clk);
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_ok", out_fcs_ok, 1'b0);
    end
    rst = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0;
    open = 1'b0;
    mbytes.delete();
`ifdef LDL_CRC32_CHK_STAT_EN
    m_good = 0; m_bad = 0;
`endif
  endtask

  task automatic make_frame(input int plen, input logic good);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
    f = ~crc_refl(frm);
    for (int i = 0; i < 4; i++) frm.push_back(f[i*8+:8]);
    if (!good) begin
      int p;
      p = $urandom_range(frm.size() - 1);
      frm[p] ^= 8'(1 << $urandom_range(7));
    end
  endtask

  task automatic send_frame(input int cut, input logic gaps);
    int len, nb;
    logic [31:0] d;
    len = frm.size();
    nb = (len + NUM - 1) / NUM;
    for (int bi = 0; bi < nb; bi++) begin
      if (cut >= 0 && bi == cut) return;
      for (int l = 0; l < NUM; l++) begin
        int k;
        k = bi * NUM + (NUM - 1 - l);
        d[l*8+:8] = (k < len) ? frm[k] : junk;
      end
      beat(1'b1, bi == 0, bi == nb - 1, d,
           (bi == nb - 1) ? 2'(len % NUM) : 2'd0);
      if (gaps && $urandom_range(3) == 0) beat(1'b0, 1'b0, 1'b0, $urandom, 2'd0);
    end
  endtask

  initial begin
    open = 1'b0;
    junk = 8'h00;
    last_ok = 1'b0; last_abort = 1'b0; last_err = 1'b0;
    in_data = '0;
`ifdef LDL_CRC32_CHK_STAT_EN
    stat_clr = 1'b0;
    m_good = 0; m_bad = 0;
`endif
    do_reset();

    // 64-byte good frame, then the same frame with one bit flipped
    make_frame(60, 1'b1);
    send_frame(-1, 1'b0);
    check("t2_ok", last_ok, 1'b1);
    frm[10] ^= 8'h01;
    send_frame(-1, 1'b0);
    check("t3_ok", last_ok, 1'b0);
    check("t3_abort_err", {last_abort, last_err}, 2'b00);

    // 65-byte frame, partial last beat with two junk patterns
    make_frame(61, 1'b1);
    junk = 8'hA5;
    send_frame(-1, 1'b0);
    check("t4_ok_a5", last_ok, 1'b1);
    junk = 8'h3C;
    send_frame(-1, 1'b0);
    check("t4_ok_3c", last_ok, 1'b1);

    // abort by new sop, then stray eop
    make_frame(40, 1'b1);
    send_frame(5, 1'b0);
    make_frame(50, 1'b1);
    frm[0] = frm[0];
    beat(1'b1, 1'b1, 1'b0, {frm[0], frm[1], frm[2], frm[3]}, 2'd0);
    check("t5_abort", last_abort, 1'b1);
    for (int i = 0; i < 4; i++) frm.pop_front();
    open = 1'b1;
    begin
      int len, nb;
      logic [31:0] d;
      len = frm.size();
      nb = (len + NUM - 1) / NUM;
      for (int bi = 0; bi < nb; bi++) begin
        for (int l = 0; l < NUM; l++) begin
          int k;
          k = bi * NUM + (NUM - 1 - l);
          d[l*8+:8] = (k < len) ? frm[k] : junk;
        end
        beat(1'b1, 1'b0, bi == nb - 1, d,
             (bi == nb - 1) ? 2'(len % NUM) : 2'd0);
      end
    end
    check("t5_ok", last_ok, 1'b1);
    beat(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0);
    check("t5_err", {last_err, last_ok}, 2'b10);

    // reset in the middle of a frame loses it without abort
    make_frame(30, 1'b1);
    send_frame(3, 1'b0);
    do_reset();
    make_frame(30, 1'b1);
    send_frame(-1, 1'b0);
    check("rst_mid_ok", {last_ok, last_abort}, 2'b10);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int r;
      r = $urandom_range(99);
      junk = 8'($urandom);
      if (r < 60) begin
        make_frame($urandom_range(1, 76), $urandom_range(1) == 1);
        send_frame(-1, 1'b1);
      end else if (r < 72) begin
        make_frame($urandom_range(8, 40), 1'b1);
        send_frame($urandom_range(1, 2), 1'b1);
      end else if (r < 82) begin
        beat(1'b1, 1'b0, 1'b1, $urandom, 2'($urandom));
      end else if (r < 92) begin
        beat(1'b1, 1'b0, 1'b0, $urandom, 2'($urandom));
      end else begin
        beat(1'b0, 1'b0, 1'b0, $urandom, 2'd0);
      end
    end

`ifdef LDL_CRC32_CHK_STAT_EN
    do_reset();
    for (int i = 0; i < 2; i++) begin
      make_frame(20, 1'b1); send_frame(-1, 1'b0);
      make_frame(20, 1'b0); send_frame(-1, 1'b0);
    end
    make_frame(20, 1'b1); send_frame(2, 1'b0);
    make_frame(20, 1'b1); send_frame(-1, 1'b0);
    check("t6_good", stat_good_cnt, 32'd3);
    check("t6_bad", stat_bad_cnt, 32'd3);
    stat_clr = 1'b1;
    make_frame(20, 1'b1); send_frame(-1, 1'b0);
    stat_clr = 1'b0;
    check("t6_clr", {stat_good_cnt, stat_bad_cnt}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
